mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port unified program/data memory (MWORDS x BUSW) between two requesters:
//  - port F (instruction fetch into IReg)
//  - port D (LD/STR data access)
//  Issues at most one memory access per cycle and returns read data one cycle later, tagged to its owner.
//  Data wins by default; a starvation counter guarantees fetch progress.
//  A halt handshake drains outstanding reads so the CPU sequencer can stop cleanly on HLT.
// PARAMETERS
//  BUSW       32    memory word width
//  MINDW      12    memory address width (MWORDS = 2**MINDW)
//  STARVE_MAX 3     consecutive cycles F may lose to D before F is forced to win (1..15)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  f_req      in   1      fetch read request; held with f_addr until f_gnt
//  f_addr     in   MINDW  fetch address (PCntr)
//  f_gnt      out  1      fetch access issued this cycle
//  f_rvalid   out  1      f_rdata valid (one cycle after f_gnt)
//  f_rdata    out  BUSW   fetched instruction word
//  d_req      in   1      data request; held with d_we/d_addr/d_wdata until d_gnt
//  d_we       in   1      1 = store (STR), 0 = load (LD)
//  d_addr     in   MINDW  data address
//  d_wdata    in   BUSW   store data
//  d_gnt      out  1      data access issued this cycle
//  d_rvalid   out  1      d_rdata valid (one cycle after a d_gnt with d_we=0)
//  d_rdata    out  BUSW   load data
//  mem_en     out  1      memory access strobe
//  mem_we     out  1      memory write enable
//  mem_addr   out  MINDW  memory address
//  mem_wdata  out  BUSW   memory write data
//  mem_rdata  in   BUSW   memory read data, valid the cycle after mem_en & ~mem_we
//  halt_req   in   1      level; stop granting and drain
//  halted     out  1      arbiter idle, no access outstanding
// BEHAVIOUR
//  Reset (async, rst_n=0): state=RUN, starve_cnt=0, resp_owner=NONE.
//   All outputs 0; f_rdata/d_rdata = 0.
//  Arbitration (combinational from req, state, starve_cnt), in RUN state only:
//  - Only d_req: D granted.
//  - Only f_req: F granted.
//  - Both asserted: D granted unless starve_cnt == STARVE_MAX, in which case F is granted.
//  - f_gnt and d_gnt are never both 1 in the same cycle.
//  - mem_en = f_gnt | d_gnt.
//  - mem_addr/mem_we/mem_wdata are taken from the winner; mem_we = d_gnt & d_we.
//  - All memory outputs are 0 when no grant is issued.
//  starve_cnt update (registered):
//  - Increments (saturating at STARVE_MAX) when f_req=1 and F is not granted.
//  - Clears when F is granted, or when f_req=0.
//  Read response (registered):
//  - resp_owner <= F / D / NONE per this cycle's read grant (a write grant records NONE).
//  - Next cycle: the owner's rvalid=1 and its rdata = mem_rdata.
//  - The non-owner's rvalid=0 and its rdata holds its last value.
//  - Stores never produce rvalid.
//  - Latency grant->rvalid = exactly 1 cycle; back-to-back grants yield back-to-back rvalids.
//  FSM:
//  - RUN -> DRAIN when halt_req=1.
//    The halt_req cycle issues no grant (halt beats all requests in the same cycle).
//  - DRAIN: no grants. Moves to HALTED once resp_owner==NONE; a pending response is still delivered.
//  - HALTED: halted=1, no grants, starve_cnt cleared.
//    Returns to RUN on the first cycle halt_req=0 (halted drops that same cycle).
//  - DRAIN with halt_req=0 returns to RUN.
//  Boundaries:
//  - Addresses wrap at MINDW bits; no range error.
//  - Requests dropped before their grant are legal: nothing is issued.
//  - Reset asserted mid-read discards the pending rvalid.
// TESTING
//  1. F only, f_addr=0x002 every cycle, mem returns 0x10000000
//     -> f_gnt every cycle; f_rvalid 1 cycle later; f_rdata=0x10000000.
//  2. F+D both held, STARVE_MAX=3
//     -> grant pattern D,D,D,F repeating; F never waits more than 3 cycles.
//  3. D store d_addr=0x001, d_wdata=113, then D load 0x001
//     -> mem_we=1 for one cycle with no d_rvalid; then d_rvalid with d_rdata=113.
//  4. halt_req asserted the cycle after a fetch grant
//     -> no further grants; f_rvalid still delivered; halted=1 the next cycle.
//     halt_req=0 -> halted=0 and grants resume the same cycle.
//  5. rst_n pulsed low between grant and response
//     -> all outputs 0 immediately; no rvalid after release; starve_cnt=0.
//  6. f_addr=0xFFF, then 0x000 -> both issued correctly, no error; mem_addr matches the grant each cycle.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (fetch F, data D), the unified
// single-port memory and the halt handshake of mem_port_arbiter.
//   slave  : the arbiter's view (takes requests, drives grants/responses
//            and the memory command, receives mem_rdata).
//   master : the surrounding CPU/memory view (drives requests, halt_req
//            and mem_rdata, observes grants, responses and halted).
interface mem_port_arbiter_if #(
  parameter int BUSW  = 32,
  parameter int MINDW = 12
);
  // fetch port
  logic             f_req;
  logic [MINDW-1:0] f_addr;
  logic             f_gnt;
  logic             f_rvalid;
  logic [BUSW-1:0]  f_rdata;
  // data port
  logic             d_req;
  logic             d_we;
  logic [MINDW-1:0] d_addr;
  logic [BUSW-1:0]  d_wdata;
  logic             d_gnt;
  logic             d_rvalid;
  logic [BUSW-1:0]  d_rdata;
  // memory command / read return
  logic             mem_en;
  logic             mem_we;
  logic [MINDW-1:0] mem_addr;
  logic [BUSW-1:0]  mem_wdata;
  logic [BUSW-1:0]  mem_rdata;
  // halt handshake
  logic             halt_req;
  logic             halted;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, halt_req,
    output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, halted
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, halt_req,
    input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, halted
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port program/data memory between instruction fetch (F)
// and LD/STR data access (D). At most one access is issued per cycle; read
// data comes back one cycle later on the owner's rvalid/rdata. D wins a
// conflict unless F has already lost STARVE_MAX cycles in a row. A halt
// handshake stops granting, lets the outstanding read finish and then
// reports halted.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mem_port_arbiter_if.slave: F/D request ports, memory command,
//          mem_rdata return, halt_req/halted
module mem_port_arbiter #(
  parameter int BUSW       = 32,
  parameter int MINDW      = 12,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e          state_q, state_d;
  owner_e          resp_owner_q, resp_owner_d;
  logic [3:0]      starve_cnt_q, starve_cnt_d;
  logic [BUSW-1:0] f_rdata_q, f_rdata_d;
  logic [BUSW-1:0] d_rdata_q, d_rdata_d;
  logic            grant_ok;
  logic            f_win;
  logic            d_win;

  function automatic logic [3:0] starve_inc(input logic [3:0] cnt);
    if (cnt >= STARVE_LIM) return STARVE_LIM;
    else                   return cnt + 4'd1;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      resp_owner_q <= OWN_NONE;
      starve_cnt_q <= '0;
      f_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      resp_owner_q <= resp_owner_d;
      starve_cnt_q <= starve_cnt_d;
      f_rdata_q    <= f_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (bus.halt_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!bus.halt_req)                state_d = ST_RUN;
        else if (resp_owner_q == OWN_NONE) state_d = ST_HALTED;
      end
      ST_HALTED: if (!bus.halt_req) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // Outputs: arbitration, memory command, read return, halted
  always_comb begin
    // rst_n gates the grants so nothing is issued while reset is held,
    // even though the state flop already reads RUN. HALTED with halt_req
    // low grants in the same cycle it leaves, DRAIN never grants.
    grant_ok = rst_n && !bus.halt_req &&
               ((state_q == ST_RUN) || (state_q == ST_HALTED));
    f_win = 1'b0;
    d_win = 1'b0;
    if (grant_ok) begin
      if (bus.d_req && !(bus.f_req && (starve_cnt_q == STARVE_LIM))) d_win = 1'b1;
      else if (bus.f_req)                                           f_win = 1'b1;
    end

    bus.f_gnt     = f_win;
    bus.d_gnt     = d_win;
    bus.mem_en    = f_win | d_win;
    bus.mem_we    = d_win & bus.d_we;
    bus.mem_addr  = f_win ? bus.f_addr : (d_win ? bus.d_addr : '0);
    bus.mem_wdata = d_win ? bus.d_wdata : '0;

    // Owner sees mem_rdata directly; the other port keeps its last word.
    bus.f_rvalid  = (resp_owner_q == OWN_F);
    bus.d_rvalid  = (resp_owner_q == OWN_D);
    bus.f_rdata   = bus.f_rvalid ? bus.mem_rdata : f_rdata_q;
    bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : d_rdata_q;

    // Idle as soon as the drain has nothing left in flight, not only once
    // the HALTED state has been entered.
    bus.halted    = bus.halt_req &&
                    ((state_q == ST_HALTED) ||
                     ((state_q == ST_DRAIN) && (resp_owner_q == OWN_NONE)));
  end

  // Registered bookkeeping: response owner, starvation count, held rdata
  always_comb begin
    resp_owner_d = OWN_NONE;
    if (f_win)                    resp_owner_d = OWN_F;
    else if (d_win && !bus.d_we)  resp_owner_d = OWN_D;

    if (state_q == ST_HALTED)         starve_cnt_d = '0;
    else if (bus.f_req && !f_win)     starve_cnt_d = starve_inc(starve_cnt_q);
    else                              starve_cnt_d = '0;

    f_rdata_d = (resp_owner_q == OWN_F) ? bus.mem_rdata : f_rdata_q;
    d_rdata_d = (resp_owner_q == OWN_D) ? bus.mem_rdata : d_rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int SMAX = 3;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk;
  logic rst_n;

  mem_port_arbiter_if #(.BUSW(32), .MINDW(12)) bus ();

  mem_port_arbiter #(.BUSW(32), .MINDW(12), .STARVE_MAX(SMAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM model attached to the memory side.
  logic [31:0] ram [0:4095];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %b, expected %b", name, act, exp);
    else n_pass++;
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          owner;   // 0 none, 1 fetch, 2 data
    logic [31:0] data;
  } resp_t;

  resp_t       pend[$];
  logic [31:0] shadow [0:4095];
  int          m_starve;
  bit          m_halting;   // halt accepted, no longer running
  bit          m_stopped;   // drain finished
  logic [31:0] m_frd, m_drd;
  bit          g_fg, g_dg;  // model's grants of the last sampled cycle

  function automatic logic [31:0] init_word(input int i);
    if (i == 2) return 32'h1000_0000;
    return 32'hA500_0000 | 32'(i);
  endfunction

  task automatic model_reset();
    pend.delete();
    m_starve  = 0;
    m_halting = 0;
    m_stopped = 0;
    m_frd     = '0;
    m_drd     = '0;
    g_fg      = 0;
    g_dg      = 0;
  endtask

  // Evaluate one cycle at the falling edge: compare DUT against the model,
  // then advance the model as the rising edge will.
  task automatic sample();
    resp_t       cur, nxt;
    int          win;
    bit          can_grant, e_we, e_halted;
    logic [11:0] e_addr;
    logic [31:0] e_wdata;
    @(negedge clk);
    cur.owner = 0;
    cur.data  = '0;
    if (pend.size() > 0) cur = pend.pop_front();
    if (cur.owner == 1) m_frd = cur.data;
    if (cur.owner == 2) m_drd = cur.data;

    can_grant = !bus.halt_req && !(m_halting && !m_stopped);
    win = 0;
    if (can_grant) begin
      if (bus.d_req && !(bus.f_req && m_starve == SMAX)) win = 2;
      else if (bus.f_req)                                win = 1;
    end
    e_addr   = (win == 1) ? bus.f_addr : ((win == 2) ? bus.d_addr : 12'h000);
    e_we     = (win == 2) && bus.d_we;
    e_wdata  = (win == 2) ? bus.d_wdata : 32'h0;
    e_halted = bus.halt_req && m_halting && (m_stopped || cur.owner == 0);

    chk1("m_f_gnt",     bus.f_gnt,     win == 1);
    chk1("m_d_gnt",     bus.d_gnt,     win == 2);
    chk1("m_gnt_excl",  bus.f_gnt & bus.d_gnt, 1'b0);
    chk1("m_mem_en",    bus.mem_en,    win != 0);
    chk1("m_mem_we",    bus.mem_we,    e_we);
    chkw("m_mem_addr",  {20'h0, bus.mem_addr}, {20'h0, e_addr});
    chkw("m_mem_wdata", bus.mem_wdata, e_wdata);
    chk1("m_f_rvalid",  bus.f_rvalid,  cur.owner == 1);
    chkw("m_f_rdata",   bus.f_rdata,   m_frd);
    chk1("m_d_rvalid",  bus.d_rvalid,  cur.owner == 2);
    chkw("m_d_rdata",   bus.d_rdata,   m_drd);
    chk1("m_halted",    bus.halted,    e_halted);

    nxt.owner = 0;
    nxt.data  = '0;
    if (win == 1) begin
      nxt.owner = 1; nxt.data = shadow[bus.f_addr];
    end else if (win == 2 && !bus.d_we) begin
      nxt.owner = 2; nxt.data = shadow[bus.d_addr];
    end
    pend.push_back(nxt);
    if (e_we) shadow[bus.d_addr] = bus.d_wdata;

    if (m_stopped)                     m_starve = 0;
    else if (bus.f_req && win != 1)    m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
    else                               m_starve = 0;

    if (!bus.halt_req) begin
      m_halting = 0; m_stopped = 0;
    end else if (!m_halting) begin
      m_halting = 1;
    end else if (!m_stopped && cur.owner == 0) begin
      m_stopped = 1;
    end
    g_fg = (win == 1);
    g_dg = (win == 2);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic fr, input logic [11:0] fa, input logic dr,
                        input logic dw, input logic [11:0] da, input logic [31:0] dd,
                        input logic hr);
    bus.f_req = fr; bus.f_addr = fa;
    bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
    bus.halt_req = hr;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_f_gnt"},    bus.f_gnt,    1'b0);
    chk1({tag, "_d_gnt"},    bus.d_gnt,    1'b0);
    chk1({tag, "_mem_en"},   bus.mem_en,   1'b0);
    chk1({tag, "_mem_we"},   bus.mem_we,   1'b0);
    chkw({tag, "_mem_addr"}, {20'h0, bus.mem_addr}, 32'h0);
    chkw({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
    chk1({tag, "_f_rvalid"}, bus.f_rvalid, 1'b0);
    chk1({tag, "_d_rvalid"}, bus.d_rvalid, 1'b0);
    chkw({tag, "_f_rdata"},  bus.f_rdata,  32'h0);
    chkw({tag, "_d_rdata"},  bus.d_rdata,  32'h0);
    chk1({tag, "_halted"},   bus.halted,   1'b0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        f_req;  logic [11:0] f_addr;
    logic        d_req;  logic d_we; logic [11:0] d_addr; logic [31:0] d_wdata;
    logic        halt;
    logic        e_fg;   logic e_dg; logic e_we; logic [11:0] e_addr;
    logic        e_frv;  logic [31:0] e_frd;
    logic        e_drv;  logic [31:0] e_drd;
    logic        e_halted;
  } vec_t;

  vec_t tv [15];
  logic exp_seq [4];

  initial begin
    // fetch-only stream from 0x002
    tv[0]  = '{H,12'h002, L,L,12'h000,32'h0, L,  H,L,L,12'h002, L,32'h0,         L,32'h0,         L};
    tv[1]  = '{H,12'h002, L,L,12'h000,32'h0, L,  H,L,L,12'h002, H,32'h1000_0000, L,32'h0,         L};
    tv[2]  = '{H,12'h002, L,L,12'h000,32'h0, L,  H,L,L,12'h002, H,32'h1000_0000, L,32'h0,         L};
    // F and D both held: D,D,D,F,D,D
    tv[3]  = '{H,12'h010, H,L,12'h020,32'h0, L,  L,H,L,12'h020, H,32'h1000_0000, L,32'h0,         L};
    tv[4]  = '{H,12'h010, H,L,12'h020,32'h0, L,  L,H,L,12'h020, L,32'h1000_0000, H,32'hA500_0020, L};
    tv[5]  = '{H,12'h010, H,L,12'h020,32'h0, L,  L,H,L,12'h020, L,32'h1000_0000, H,32'hA500_0020, L};
    tv[6]  = '{H,12'h010, H,L,12'h020,32'h0, L,  H,L,L,12'h010, L,32'h1000_0000, H,32'hA500_0020, L};
    tv[7]  = '{H,12'h010, H,L,12'h020,32'h0, L,  L,H,L,12'h020, H,32'hA500_0010, L,32'hA500_0020, L};
    tv[8]  = '{H,12'h010, H,L,12'h020,32'h0, L,  L,H,L,12'h020, L,32'hA500_0010, H,32'hA500_0020, L};
    // store 113 to 0x001, load it back
    tv[9]  = '{L,12'h000, H,H,12'h001,32'd113, L, L,H,H,12'h001, L,32'hA500_0010, H,32'hA500_0020, L};
    tv[10] = '{L,12'h000, H,L,12'h001,32'h0, L,  L,H,L,12'h001, L,32'hA500_0010, L,32'hA500_0020, L};
    tv[11] = '{L,12'h000, L,L,12'h000,32'h0, L,  L,L,L,12'h000, L,32'hA500_0010, H,32'd113,       L};
    // address wrap 0xFFF -> 0x000
    tv[12] = '{H,12'hFFF, L,L,12'h000,32'h0, L,  H,L,L,12'hFFF, L,32'hA500_0010, L,32'd113,       L};
    tv[13] = '{H,12'h000, L,L,12'h000,32'h0, L,  H,L,L,12'h000, H,32'hA500_0FFF, L,32'd113,       L};
    tv[14] = '{L,12'h000, L,L,12'h000,32'h0, L,  L,L,L,12'h000, H,32'hA500_0000, L,32'd113,       L};

    exp_seq[0] = L; exp_seq[1] = L; exp_seq[2] = L; exp_seq[3] = H; // H = fetch wins

    for (int i = 0; i < 4096; i++) begin
      ram[i]    = init_word(i);
      shadow[i] = init_word(i);
    end
    model_reset();

    // Reset held with both requests up: nothing may be granted.
    rst_n = 1'b0;
    set_in(H, 12'h002, H, L, 12'h003, 32'h0, L);
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    set_in(L, 12'h000, L, L, 12'h000, 32'h0, L);
    rst_n = 1'b1;
    sample(); adv();

    for (int i = 0; i < 15; i++) begin
      set_in(tv[i].f_req, tv[i].f_addr, tv[i].d_req, tv[i].d_we,
             tv[i].d_addr, tv[i].d_wdata, tv[i].halt);
      sample();
      chk1($sformatf("tv%0d_f_gnt", i),    bus.f_gnt,    tv[i].e_fg);
      chk1($sformatf("tv%0d_d_gnt", i),    bus.d_gnt,    tv[i].e_dg);
      chk1($sformatf("tv%0d_mem_we", i),   bus.mem_we,   tv[i].e_we);
      chkw($sformatf("tv%0d_mem_addr", i), {20'h0, bus.mem_addr}, {20'h0, tv[i].e_addr});
      chk1($sformatf("tv%0d_f_rvalid", i), bus.f_rvalid, tv[i].e_frv);
      chkw($sformatf("tv%0d_f_rdata", i),  bus.f_rdata,  tv[i].e_frd);
      chk1($sformatf("tv%0d_d_rvalid", i), bus.d_rvalid, tv[i].e_drv);
      chkw($sformatf("tv%0d_d_rdata", i),  bus.d_rdata,  tv[i].e_drd);
      chk1($sformatf("tv%0d_halted", i),   bus.halted,   tv[i].e_halted);
      adv();
    end

    // Halt one cycle after a fetch grant; drain, halt, resume.
    set_in(H, 12'h004, L, L, 12'h000, 32'h0, L);
    sample();
    chk1("halt_a_f_gnt", bus.f_gnt, H);
    adv();
    set_in(H, 12'h005, H, L, 12'h040, 32'h0, H);
    sample();
    chk1("halt_b_mem_en", bus.mem_en, L);
    chk1("halt_b_f_rvalid", bus.f_rvalid, H);
    chkw("halt_b_f_rdata", bus.f_rdata, 32'hA500_0004);
    chk1("halt_b_halted", bus.halted, L);
    adv();
    sample();
    chk1("halt_c_mem_en", bus.mem_en, L);
    chk1("halt_c_f_rvalid", bus.f_rvalid, L);
    chk1("halt_c_halted", bus.halted, H);
    adv();
    sample();
    chk1("halt_d_mem_en", bus.mem_en, L);
    chk1("halt_d_halted", bus.halted, H);
    adv();
    bus.halt_req = L;
    sample();
    chk1("halt_e_halted", bus.halted, L);
    chk1("halt_e_d_gnt", bus.d_gnt, H);
    chkw("halt_e_mem_addr", {20'h0, bus.mem_addr}, 32'h040);
    adv();
    set_in(L, 12'h000, L, L, 12'h000, 32'h0, L);
    sample();
    chk1("halt_f_d_rvalid", bus.d_rvalid, H);
    chkw("halt_f_d_rdata", bus.d_rdata, 32'hA500_0040);
    adv();

    // Reset between a fetch grant and its response.
    set_in(H, 12'h007, L, L, 12'h000, 32'h0, L);
    sample();
    chk1("rst_g_f_gnt", bus.f_gnt, H);
    adv();
    rst_n = 1'b0;
    set_in(H, 12'h007, H, L, 12'h030, 32'h0, L);
    #1;
    chk_all_zero("midrst");
    model_reset();
    adv();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sample();
      if (k == 0) chk1("rst_no_rvalid", bus.f_rvalid, L);
      chk1($sformatf("rst_seq%0d_f_gnt", k), bus.f_gnt, exp_seq[k]);
      chk1($sformatf("rst_seq%0d_d_gnt", k), bus.d_gnt, !exp_seq[k]);
      adv();
    end
    set_in(L, 12'h000, L, L, 12'h000, 32'h0, L);
    sample(); adv();

    // Random traffic: requests stay up until granted (occasionally dropped).
    for (int c = 0; c < 2000; c++) begin
      if (!(bus.f_req && !g_fg) || $urandom_range(0, 15) == 0) begin
        bus.f_req  = ($urandom_range(0, 3) != 0);
        bus.f_addr = 12'($urandom);
      end
      if (!(bus.d_req && !g_dg) || $urandom_range(0, 15) == 0) begin
        bus.d_req   = ($urandom_range(0, 2) != 0);
        bus.d_we    = ($urandom_range(0, 2) == 0);
        bus.d_addr  = 12'($urandom_range(0, 63));
        bus.d_wdata = $urandom;
      end
      if ($urandom_range(0, 24) == 0) bus.halt_req = !bus.halt_req;
      sample();
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
